// File: rtl/timer_capture_buffer.sv
// Tagged first-word-fall-through FIFO that buffers timer capture and alarm events.
// A full buffer drops new events and counts them rather than stalling the timer.
module timer_capture_buffer #(
  parameter int TIMER_WIDTH    = 32,
  parameter int DEPTH          = 8,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         areset,
  input  logic                         sreset,
  input  logic                         cap_valid,
  input  logic [TIMER_WIDTH-1:0]       cap_value,
  input  logic                         alarm_valid,
  input  logic                         rd_ready,
  output logic                         rd_valid,
  output logic [TIMER_WIDTH-1:0]       rd_data,
  output logic [1:0]                   rd_tag,
  output logic [$clog2(DEPTH+1)-1:0]   fill_level,
  output logic                         overflow,
  output logic [DROP_CNT_WIDTH-1:0]    drop_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH+1);
  localparam int EW = TIMER_WIDTH + 2;

  logic [EW-1:0]             r_mem [DEPTH];
  logic [PW-1:0]             r_wptr;
  logic [PW-1:0]             r_rptr;
  logic [FW-1:0]             r_fill;
  logic                      r_valid;
  logic [TIMER_WIDTH-1:0]    r_data;
  logic [1:0]                r_tag;
  logic                      r_ovf;
  logic [DROP_CNT_WIDTH-1:0] r_drop;

  logic                      w_ev;
  logic                      w_pop;
  logic                      w_full;
  logic                      w_acc;
  logic                      w_bypass;
  logic [EW-1:0]             w_entry;
  logic [PW-1:0]             w_rptr_nxt;
  logic [FW-1:0]             w_fill_nxt;

  assign w_ev       = cap_valid | alarm_valid;
  assign w_pop      = r_valid & rd_ready;
  assign w_full     = (r_fill == FW'(DEPTH));
  assign w_acc      = w_ev & (~w_full | w_pop);
  assign w_entry    = {alarm_valid, cap_valid,
                       cap_valid ? cap_value : {TIMER_WIDTH{1'b0}}};
  assign w_rptr_nxt = r_rptr + PW'(1);

  // New entry becomes head directly when the buffer is, or is about to be, empty.
  assign w_bypass = w_acc & ((r_fill == '0) |
                             (w_pop & (r_fill == FW'(1))));

  always_comb begin
    w_fill_nxt = r_fill;
    unique case ({w_acc, w_pop})
      2'b10:   w_fill_nxt = r_fill + FW'(1);
      2'b01:   w_fill_nxt = r_fill - FW'(1);
      default: w_fill_nxt = r_fill;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_acc & ~sreset)
      r_mem[r_wptr] <= w_entry;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_fill  <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_tag   <= '0;
      r_ovf   <= 1'b0;
      r_drop  <= '0;
    end else if (sreset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_fill  <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_tag   <= '0;
      r_ovf   <= 1'b0;
      r_drop  <= '0;
    end else begin
      r_fill  <= w_fill_nxt;
      r_valid <= (w_fill_nxt != '0);
      if (w_acc)
        r_wptr <= r_wptr + PW'(1);
      if (w_pop)
        r_rptr <= w_rptr_nxt;
      if (w_bypass)
        {r_tag, r_data} <= w_entry;
      else if (w_pop && (w_fill_nxt != '0))
        {r_tag, r_data} <= r_mem[w_rptr_nxt];
      if (w_ev & ~w_acc) begin
        r_ovf <= 1'b1;
        if (~&r_drop)
          r_drop <= r_drop + DROP_CNT_WIDTH'(1);
      end
    end
  end

  assign rd_valid   = r_valid;
  assign rd_data    = r_data;
  assign rd_tag     = r_tag;
  assign fill_level = r_fill;
  assign overflow   = r_ovf;
  assign drop_count = r_drop;

endmodule

// File: tb/tb_timer_capture_buffer.sv
// Randomized and directed bench for timer_capture_buffer.
// Expected behaviour comes from a queue model of the event buffer.
module tb_timer_capture_buffer;

  localparam int DEPTH = 8;

  logic        clk;
  logic        areset;
  logic        sreset;
  logic        cap_valid;
  logic [31:0] cap_value;
  logic        alarm_valid;
  logic        rd_ready;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [1:0]  rd_tag;
  logic [3:0]  fill_level;
  logic        overflow;
  logic [15:0] drop_count;

  timer_capture_buffer #(
    .TIMER_WIDTH(32),
    .DEPTH(DEPTH),
    .DROP_CNT_WIDTH(16)
  ) u_dut (
    .clk(clk),
    .areset(areset),
    .sreset(sreset),
    .cap_valid(cap_valid),
    .cap_value(cap_value),
    .alarm_valid(alarm_valid),
    .rd_ready(rd_ready),
    .rd_valid(rd_valid),
    .rd_data(rd_data),
    .rd_tag(rd_tag),
    .fill_level(fill_level),
    .overflow(overflow),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  logic [33:0] q[$];
  int m_ovf;
  int m_drop;
  int seg_issued;
  int seg_popped;

  task automatic expect_eq(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_ovf = 0;
    m_drop = 0;
    seg_issued = 0;
    seg_popped = 0;
  endtask

  task automatic check_outputs();
    expect_eq("rd_valid", 64'(rd_valid), 64'(q.size() > 0));
    expect_eq("fill_level", 64'(fill_level), 64'(q.size()));
    expect_eq("overflow", 64'(overflow), 64'(m_ovf));
    expect_eq("drop_count", 64'(drop_count), 64'(m_drop));
    if (q.size() > 0) begin
      expect_eq("rd_data", 64'(rd_data), 64'(q[0][31:0]));
      expect_eq("rd_tag", 64'(rd_tag), 64'(q[0][33:32]));
    end
  endtask

  task automatic check_zero(input string tag);
    expect_eq({tag, "_valid"}, 64'(rd_valid), 64'd0);
    expect_eq({tag, "_data"}, 64'(rd_data), 64'd0);
    expect_eq({tag, "_tag"}, 64'(rd_tag), 64'd0);
    expect_eq({tag, "_fill"}, 64'(fill_level), 64'd0);
    expect_eq({tag, "_ovf"}, 64'(overflow), 64'd0);
    expect_eq({tag, "_drop"}, 64'(drop_count), 64'd0);
  endtask

  task automatic step(input logic c, input logic [31:0] v, input logic a,
                      input logic r, input logic s);
    bit pop;
    int sz;
    cap_valid   = c;
    cap_value   = v;
    alarm_valid = a;
    rd_ready    = r;
    sreset      = s;
    sz  = q.size();
    pop = (sz > 0) && r;
    if (s) begin
      model_clear();
    end else begin
      if (pop) begin
        void'(q.pop_front());
        seg_popped++;
      end
      if (c | a) begin
        seg_issued++;
        if (sz < DEPTH || pop)
          q.push_back({a, c, c ? v : 32'h0});
        else begin
          m_ovf = 1;
          if (m_drop < 65535)
            m_drop++;
        end
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic areset_pulse();
    cap_valid   = 1'b0;
    alarm_valid = 1'b0;
    rd_ready    = 1'b0;
    sreset      = 1'b0;
    #2;
    areset = 1'b1;
    #1;
    check_zero("areset_async");
    model_clear();
    @(negedge clk);
    areset = 1'b0;
  endtask

  task automatic check_accounting(input string tag);
    expect_eq(tag, 64'(seg_popped + int'(fill_level) + int'(drop_count)),
              64'(seg_issued));
  endtask

  initial begin
    int ev_total;
    int cycles;
    bit pulsed;
    n_chk = 0;
    n_fail = 0;
    areset = 1'b1;
    sreset = 1'b0;
    cap_valid = 1'b0;
    cap_value = '0;
    alarm_valid = 1'b0;
    rd_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    areset = 1'b0;

    // single capture, popped on the first visible cycle
    step(1'b1, 32'h1234, 1'b0, 1'b1, 1'b0);
    expect_eq("t1_data", 64'(rd_data), 64'h1234);
    expect_eq("t1_tag", 64'(rd_tag), 64'h1);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    expect_eq("t1_fill", 64'(fill_level), 64'h0);

    // combined capture+alarm, then alarm alone
    step(1'b1, 32'd500, 1'b1, 1'b0, 1'b0);
    expect_eq("t2_data", 64'(rd_data), 64'd500);
    expect_eq("t2_tag", 64'(rd_tag), 64'h3);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'hdead, 1'b1, 1'b0, 1'b0);
    expect_eq("t2_adata", 64'(rd_data), 64'h0);
    expect_eq("t2_atag", 64'(rd_tag), 64'h2);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    // overflow: 10 captures into 8 slots
    for (int i = 1; i <= 10; i++)
      step(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
    expect_eq("t3_fill", 64'(fill_level), 64'd8);
    expect_eq("t3_ovf", 64'(overflow), 64'd1);
    expect_eq("t3_drop", 64'(drop_count), 64'd2);
    expect_eq("t3_head", 64'(rd_data), 64'd1);

    // full with same-cycle pop accepts the event
    step(1'b1, 32'd99, 1'b0, 1'b1, 1'b0);
    expect_eq("t4_fill", 64'(fill_level), 64'd8);
    expect_eq("t4_drop", 64'(drop_count), 64'd2);
    expect_eq("t4_head", 64'(rd_data), 64'd2);
    repeat (8) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    expect_eq("t4_empty", 64'(fill_level), 64'd0);
    expect_eq("t4_ovf_sticky", 64'(overflow), 64'd1);

    // sreset with a concurrent strobe
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'(40 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'd77, 1'b0, 1'b0, 1'b1);
    check_zero("t5_sreset_");
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    expect_eq("t5_absent", 64'(rd_valid), 64'd0);

    // randomized run with a mid-run asynchronous reset
    model_clear();
    ev_total = 0;
    cycles = 0;
    pulsed = 0;
    while (ev_total < 100 && cycles < 2000) begin
      logic c;
      logic a;
      logic r;
      c = ($urandom_range(0, 99) < 35);
      a = ($urandom_range(0, 99) < 15);
      r = ($urandom_range(0, 99) < 30);
      if (c | a)
        ev_total++;
      step(c, $urandom, a, r, 1'b0);
      cycles++;
      if (!pulsed && ev_total >= 50) begin
        pulsed = 1;
        check_accounting("rand_acct_pre");
        areset_pulse();
      end
    end
    expect_eq("rand_budget", 64'(ev_total >= 100), 64'd1);
    repeat (10) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    check_accounting("rand_acct_post");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
